// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Brief    : Shared UART definitions: bit period, byte type, rx FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 100 MHz / 115200 baud
    localparam int unsigned c_CLK_PER_BIT = 868;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock first-word-fall-through FIFO with occupancy count.
//            DEPTH must be a power of two so the pointers wrap naturally.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_pop_data,
    output logic                   o_valid,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int              c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL    = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL);
    assign w_pop_ok  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a push while full is accepted
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_valid    = !w_empty;
    assign o_full     = w_full;
    assign o_count    = r_count;

    // Storage array; contents are don't-care after reset so it is not reset
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_with_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_with_buffer
// Brief    : 8N1 UART receiver feeding a byte FIFO with a valid/ready pop
//            port. Framing errors and overflow drops are one-cycle pulses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_with_buffer
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = c_CLK_PER_BIT,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    output logic [7:0]                  rd_data,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        frame_error,
    output logic                        overflow,
    output logic                        busy
);

    localparam int              c_CW       = $clog2(CLK_PER_BIT);
    localparam logic [c_CW-1:0] c_FULL_BIT = c_CW'(CLK_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_HALF_BIT = c_CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;

    rx_state_t       r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_bit_idx;
    byte_t           r_shreg;
    logic            r_frame_error;
    logic            r_overflow;

    logic w_sample;
    logic w_stop_ok;
    logic w_fifo_full;
    logic w_drop;
    logic w_push;

    // Metastability chain on the asynchronous line, idles high
    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge clk) begin
                if (rst) r_sync <= '1;
                else     r_sync <= rx;
            end
        end else begin : g_sync_chain
            always_ff @(posedge clk) begin
                if (rst) r_sync <= '1;
                else     r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
            end
        end
    endgenerate

    assign w_rxs = r_sync[SYNC_STAGES-1];

    assign w_sample  = (r_cnt == '0);
    assign w_stop_ok = (r_state == STOP) && w_sample && w_rxs;
    // When full, the head is valid, so rd_ready alone decides if a slot frees up
    assign w_drop    = w_stop_ok && w_fifo_full && !rd_ready;
    assign w_push    = w_stop_ok && !w_drop;

    // Receive FSM: bit timing, deserialisation and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_shreg       <= '0;
            r_frame_error <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_frame_error <= 1'b0;
            r_overflow    <= w_drop;
            if (!w_sample) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state <= START;
                        r_cnt   <= c_HALF_BIT;
                    end
                end
                START: begin
                    if (w_sample) begin
                        if (!w_rxs) begin
                            r_state   <= DATA;
                            r_cnt     <= c_FULL_BIT;
                            r_bit_idx <= 3'd0;
                        end else begin
                            // line went back high before mid start bit: glitch
                            r_state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (w_sample) begin
                        r_shreg <= {w_rxs, r_shreg[7:1]};
                        r_cnt   <= c_FULL_BIT;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (w_sample) begin
                        if (w_rxs) begin
                            // leave mid stop bit so a back-to-back start is caught
                            r_state <= IDLE;
                        end else begin
                            r_frame_error <= 1'b1;
                            r_state       <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (w_rxs) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign frame_error = r_frame_error;
    assign overflow    = r_overflow;
    assign busy        = (r_state != IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (r_shreg),
        .i_pop       (rd_ready),
        .o_pop_data  (rd_data),
        .o_valid     (rd_valid),
        .o_full      (w_fifo_full),
        .o_count     (count)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_with_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_with_buffer
// Brief    : Scoreboard bench for the UART receiver with byte FIFO. A short
//            bit period keeps the run compact.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_with_buffer;

    localparam int CPB   = 64;
    localparam int DEPTH = 16;
    localparam int SYNC  = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    // sync chain + idle detect + half bit + start and eight data bits
    localparam int LAT   = SYNC + 1 + CPB / 2 + 9 * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          rd_ready = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [CW-1:0] count;
    logic          frame_error;
    logic          overflow;
    logic          busy;

    uart_rx_with_buffer #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .count       (count),
        .frame_error (frame_error),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    int         exp_ovf = 0;
    int         ferr_seen = 0;
    int         ovf_seen = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         rise_cyc = 0;
    int         busy_cyc = 0;
    logic       prev_valid = 1'b0;
    bit         rand_rdy = 1'b0;
    logic [7:0] t2_bytes [3] = '{8'hA3, 8'h00, 8'hFF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every handshake and tallies pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected actual=%0h expected=none", rd_data);
                end else begin
                    check("pop_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
                end
            end
            if (frame_error && overflow) begin
                checks++;
                errors++;
                $display("FAIL pulse_overlap actual=both expected=exclusive");
            end
            if (frame_error) ferr_seen <= ferr_seen + 1;
            if (overflow)    ovf_seen  <= ovf_seen + 1;
            if (busy)        busy_cyc  <= busy_cyc + 1;
            if (rd_valid && !prev_valid) rise_cyc <= cyc;
            prev_valid <= rd_valid;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            rd_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a good frame lands in the FIFO unless it already
    // holds DEPTH bytes; force_accept covers a pop coinciding with the push
    task automatic expect_byte(input logic [7:0] b, input bit force_accept);
        if (force_accept || exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovf++;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_bits);
        start_cyc = cyc;
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(CPB);
        end
        rx = stop_bit;
        wait_cycles(CPB * stop_bits);
    endtask

    task automatic drain(input string tag);
        rd_ready = 1'b1;
        wait_cycles(2 * DEPTH + 4);
        check({tag, "_drain_count"}, 32'(count), 32'd0);
        check({tag, "_drain_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_model_left"}, exp_q.size(), 32'd0);
        rd_ready = 1'b0;
    endtask

    task automatic check_pulses(input string tag);
        check({tag, "_frame_err"}, ferr_seen, exp_ferr);
        check({tag, "_overflow"}, ovf_seen, exp_ovf);
    endtask

    initial begin
        wait_cycles(4);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ferr", 32'(frame_error), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_cycles(5);

        // single frame, held in the FIFO
        expect_byte(8'h55, 1'b0);
        send_frame(8'h55, 1'b1, 1);
        wait_cycles(CPB);
        check("t1_latency", rise_cyc - start_cyc, LAT);
        check("t1_valid", 32'(rd_valid), 32'd1);
        check("t1_data", 32'(rd_data), 32'h55);
        check("t1_count", 32'(count), 32'd1);
        check_pulses("t1");
        drain("t1");

        // back-to-back frames, popped in order afterwards
        for (int i = 0; i < 3; i++) begin
            expect_byte(t2_bytes[i], 1'b0);
            send_frame(t2_bytes[i], 1'b1, 1);
        end
        wait_cycles(CPB);
        check("t2_count", 32'(count), 32'd3);
        drain("t2");
        check_pulses("t2");

        // short low glitch rejected in START
        busy_cyc = 0;
        rx = 1'b0;
        wait_cycles(20);
        rx = 1'b1;
        wait_cycles(2 * CPB);
        check("t3_busy_cycles", busy_cyc, CPB / 2);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_count", 32'(count), 32'd0);
        check_pulses("t3");

        // framing error, line held low, then a good frame
        exp_ferr++;
        send_frame(8'h3C, 1'b0, 2);
        check("t4_busy_break", 32'(busy), 32'd1);
        rx = 1'b1;
        wait_cycles(SYNC + 3);
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_count_err", 32'(count), 32'd0);
        expect_byte(8'h12, 1'b0);
        send_frame(8'h12, 1'b1, 1);
        wait_cycles(CPB);
        check("t4_count", 32'(count), 32'd1);
        check("t4_data", 32'(rd_data), 32'h12);
        check_pulses("t4");
        drain("t4");

        // overflow on the seventeenth byte
        for (int i = 0; i < 17; i++) begin
            expect_byte(8'(i), 1'b0);
            send_frame(8'(i), 1'b1, 1);
        end
        wait_cycles(CPB);
        check("t5a_count", 32'(count), 32'd16);
        check_pulses("t5a");
        drain("t5a");

        // pop coinciding with the push into a full FIFO
        for (int i = 0; i < 16; i++) begin
            expect_byte(8'(i), 1'b0);
            send_frame(8'(i), 1'b1, 1);
        end
        expect_byte(8'h10, 1'b1);
        fork
            send_frame(8'h10, 1'b1, 1);
            begin
                wait_cycles(LAT - 1);
                rd_ready = 1'b1;
                wait_cycles(1);
                rd_ready = 1'b0;
            end
        join
        wait_cycles(CPB);
        check("t5b_count", 32'(count), 32'd16);
        check_pulses("t5b");
        drain("t5b");

        // reset in the middle of bit 4 of 0x81 with two bytes queued
        expect_byte(8'h11, 1'b0);
        send_frame(8'h11, 1'b1, 1);
        expect_byte(8'h22, 1'b0);
        send_frame(8'h22, 1'b1, 1);
        wait_cycles(CPB);
        check("t6_pre_count", 32'(count), 32'd2);
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0);
            wait_cycles(CPB);
        end
        rx = 1'b0;
        wait_cycles(CPB / 2);
        rst = 1'b1;
        rx = 1'b1;
        wait_cycles(1);
        check("t6_valid", 32'(rd_valid), 32'd0);
        check("t6_count", 32'(count), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        wait_cycles(4);
        rd_ready = 1'b1;
        expect_byte(8'h81, 1'b0);
        send_frame(8'h81, 1'b1, 1);
        wait_cycles(CPB);
        check("t6_post_count", 32'(count), 32'd0);
        check("t6_model_left", exp_q.size(), 32'd0);
        check_pulses("t6");
        rd_ready = 1'b0;

        // random bytes, gaps and consumer stalls, with occasional bad stop bits
        rand_rdy = 1'b1;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            int         gap;
            b   = 8'($urandom);
            gap = int'($urandom_range(0, 3 * CPB));
            if ($urandom_range(0, 5) == 0) begin
                exp_ferr++;
                send_frame(b, 1'b0, 1);
                rx = 1'b1;
                wait_cycles(CPB);
            end else begin
                expect_byte(b, 1'b0);
                send_frame(b, 1'b1, 1);
            end
            if (gap > 0) wait_cycles(gap);
        end
        wait_cycles(CPB);
        rand_rdy = 1'b0;
        wait_cycles(2);
        drain("rand");
        check_pulses("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
